// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, the shared memory port and the decoder.
// master = sequencer side, slave = memory/decoder side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [7:0]        mem_rdata;
  logic              is_mem_op;
  logic              mem_rw;
  logic [ADDR_W-1:0] data_addr;
  logic [7:0]        instr;
  logic              instr_valid;
  logic              load_valid;
  logic [ADDR_W-1:0] pc;

  modport master (
    output mem_req, mem_we, mem_addr, instr, instr_valid, load_valid, pc,
    input  mem_ready, mem_rdata, is_mem_op, mem_rw, data_addr
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, instr, instr_valid, load_valid, pc,
    output mem_ready, mem_rdata, is_mem_op, mem_rw, data_addr
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns the PC, fetches one byte per step
// and runs LD/ST data accesses on the same memory port before advancing.
module fetch_sequencer #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              run_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        instr_q;
  logic [ADDR_W-1:0] data_addr_q;
  logic              we_q;

  // run_q holds off the first request until one edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (run_q && bus.mem_ready) state_d = EXEC;
      EXEC:    state_d = bus.is_mem_op ? MEM : FETCH;
      MEM:     if (bus.mem_ready) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Data access address/direction are frozen at EXEC exit so the decoder may move on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= 8'h00;
      data_addr_q <= RESET_PC;
      we_q        <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (run_q && bus.mem_ready) instr_q <= bus.mem_rdata;
        end
        EXEC: begin
          if (bus.is_mem_op) begin
            data_addr_q <= bus.data_addr;
            we_q        <= bus.mem_rw;
          end else begin
            pc_q <= pc_q + ADDR_W'(1);
          end
        end
        MEM: begin
          if (bus.mem_ready) pc_q <= pc_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_req     = run_q && (state_q != EXEC);
    bus.mem_we      = (state_q == MEM) && we_q;
    bus.mem_addr    = (state_q == MEM) ? data_addr_q : pc_q;
    bus.instr_valid = (state_q == EXEC);
    bus.load_valid  = (state_q == MEM) && !we_q && bus.mem_ready;
    bus.instr       = instr_q;
    bus.pc          = pc_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a step-level model of the
// fetch/exec/mem sequence with random wait states.
module tb_fetch_sequencer;

  logic clk;
  logic reset;
  int   numChecks;
  int   numFails;

  logic [7:0] mem [256];
  logic [7:0] modelPc;
  logic [7:0] modelInstr;

  fetch_sequencer_if #(.ADDR_W(8)) bus ();
  fetch_sequencer_if #(.ADDR_W(8)) bus2 ();

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'hFF)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] nextPc(input logic [7:0] p);
    return 8'((int'(p) + 1) % 256);
  endfunction

  // One instruction step: fetch with w1 wait cycles, exec, optional data access with w2 waits.
  task automatic applyStimulus(input int w1, input int w2, input int forcedAddr);
    logic [7:0] expInstr;
    logic       isMem;
    logic       isSt;
    logic [7:0] daddr;
    for (int i = 0; i <= w1; i++) begin
      @(negedge clk);
      checkOutput("fetch_req", bus.mem_req, 1);
      checkOutput("fetch_we", bus.mem_we, 0);
      checkOutput("fetch_addr", bus.mem_addr, modelPc);
      checkOutput("fetch_valid", bus.instr_valid, 0);
      checkOutput("fetch_pc", bus.pc, modelPc);
      checkOutput("fetch_instr_hold", bus.instr, modelInstr);
      bus.mem_ready = (i == w1);
      bus.mem_rdata = (i == w1) ? mem[modelPc] : 8'($urandom);
      #1 checkOutput("fetch_load_valid", bus.load_valid, 0);
    end
    expInstr   = mem[modelPc];
    modelInstr = expInstr;
    isMem      = (expInstr[7:4] == 4'h1);
    isSt       = expInstr[3];
    if (forcedAddr >= 0) daddr = 8'(forcedAddr);
    else begin
      case ($urandom % 4)
        0:       daddr = modelPc;
        1:       daddr = nextPc(modelPc);
        default: daddr = 8'($urandom);
      endcase
    end
    @(negedge clk);
    checkOutput("exec_valid", bus.instr_valid, 1);
    checkOutput("exec_req", bus.mem_req, 0);
    checkOutput("exec_we", bus.mem_we, 0);
    checkOutput("exec_instr", bus.instr, expInstr);
    checkOutput("exec_pc", bus.pc, modelPc);
    bus.is_mem_op = isMem;
    bus.mem_rw    = isSt;
    bus.data_addr = daddr;
    bus.mem_ready = 1'($urandom % 2);
    bus.mem_rdata = 8'($urandom);
    if (!isMem) begin
      modelPc = nextPc(modelPc);
      return;
    end
    for (int i = 0; i <= w2; i++) begin
      @(negedge clk);
      checkOutput("mem_req", bus.mem_req, 1);
      checkOutput("mem_we", bus.mem_we, isSt);
      checkOutput("mem_addr", bus.mem_addr, daddr);
      checkOutput("mem_valid", bus.instr_valid, 0);
      checkOutput("mem_pc", bus.pc, modelPc);
      checkOutput("mem_instr", bus.instr, expInstr);
      bus.data_addr = ~daddr;
      bus.mem_rw    = ~isSt;
      bus.is_mem_op = 1'($urandom % 2);
      bus.mem_ready = (i == w2);
      bus.mem_rdata = (i == w2 && !isSt) ? mem[daddr] : 8'($urandom);
      #1 checkOutput("mem_load_valid", bus.load_valid, (i == w2) && !isSt);
      if (i == w2 && isSt) mem[daddr] = 8'($urandom);
    end
    modelPc = nextPc(modelPc);
  endtask

  function automatic int pickWait();
    return ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 4));
  endfunction

  // Second instance starts at FF with zero-wait non-memory instructions: checks the wrap.
  initial begin
    bus2.mem_ready = 1'b1;
    bus2.mem_rdata = 8'h08;
    bus2.is_mem_op = 1'b0;
    bus2.mem_rw    = 1'b0;
    bus2.data_addr = 8'h00;
    @(negedge reset);
    @(negedge clk);
    checkOutput("wrap_fetch_addr", bus2.mem_addr, 8'hFF);
    checkOutput("wrap_fetch_req", bus2.mem_req, 1);
    @(negedge clk);
    checkOutput("wrap_exec_valid", bus2.instr_valid, 1);
    checkOutput("wrap_exec_pc", bus2.pc, 8'hFF);
    @(negedge clk);
    checkOutput("wrap_next_addr", bus2.mem_addr, 8'h00);
    checkOutput("wrap_next_pc", bus2.pc, 8'h00);
  end

  initial begin
    numChecks     = 0;
    numFails      = 0;
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    bus.is_mem_op = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.data_addr = 8'h00;
    for (int i = 0; i < 256; i++) begin
      case ($urandom % 4)
        0:       mem[i] = 8'h10 | 8'($urandom % 8);
        1:       mem[i] = 8'h18;
        default: mem[i] = 8'($urandom);
      endcase
    end
    mem[0] = 8'h08; mem[1] = 8'h09; mem[2] = 8'h88;
    mem[3] = 8'h10; mem[4] = 8'h18; mem[8'h40] = 8'h5A;
    modelPc    = 8'h00;
    modelInstr = 8'h00;

    repeat (2) @(negedge clk);
    checkOutput("reset_req", bus.mem_req, 0);
    checkOutput("reset_pc", bus.pc, 0);
    checkOutput("reset_instr", bus.instr, 0);
    checkOutput("reset_addr", bus.mem_addr, 0);
    reset = 1'b0;

    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, -1);
    applyStimulus(0, 0, 8'h40);
    applyStimulus(1, 2, 8'h41);
    applyStimulus(4, 0, -1);

    // Reset in the middle of a stalled fetch must drop the request at once.
    @(negedge clk);
    bus.mem_ready = 1'b0;
    checkOutput("prereset_req", bus.mem_req, 1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_req", bus.mem_req, 0);
    checkOutput("midreset_pc", bus.pc, 0);
    checkOutput("midreset_instr", bus.instr, 0);
    checkOutput("midreset_valid", bus.instr_valid, 0);
    checkOutput("midreset_addr", bus.mem_addr, 0);
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("inreset_req", bus.mem_req, 0);
    bus.mem_ready = 1'b0;
    reset         = 1'b0;
    modelPc       = 8'h00;
    modelInstr    = 8'h00;

    for (int n = 0; n < 600; n++) begin
      applyStimulus(pickWait(), pickWait(), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
